// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy-bit scoreboard for hazard tracking.
// Define RF_BYPASS_EN to add same-cycle write-to-read forwarding on every read port.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Priority, lowest first: write clears, reserve sets, flush clears everything.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && !is_zero(wr_addr[k*ADDR_W +: ADDR_W]))
                busy_next[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (rsv_en && !is_zero(rsv_addr))
            busy_next[rsv_addr] = 1'b1;
        if (flush)
            busy_next = '0;
    end

    // Ascending port loop: the last non-blocking assignment wins, so the highest port takes a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && !is_zero(wr_addr[k*ADDR_W +: ADDR_W]))
                    regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
            end
            busy <= busy_next;
        end
    end

    always_comb begin : read_mux
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        rd_data = '0;
        rd_busy = '0;
        a = '0;
        d = '0;
        b = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            a = rd_addr[r*ADDR_W +: ADDR_W];
            d = regs[a];
            b = busy[a];
`ifdef RF_BYPASS_EN
            // Gated by reset so the outputs stay 0 while reset is held.
            for (int k = 0; k < NUM_WR; k++) begin
                if (reset && wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == a)) begin
                    d = wr_data[k*DATA_W +: DATA_W];
                    b = busy[a] && rsv_en && (rsv_addr == a);
                end
            end
`endif
            if (is_zero(a)) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[r*DATA_W +: DATA_W] = d;
            rd_busy[r] = b;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a vector table plus hand sequences for reset,
// ZERO_REG=0, forwarding and asynchronous reset; expectations follow RF_BYPASS_EN.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [63:0] nz_rd_data;
    logic [1:0]  nz_rd_busy;

    int checks = 0;
    int errors = 0;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_mp_sb u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regfile_mp_sb #(.ZERO_REG(0)) u_dut_nz (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(nz_rd_data), .rd_busy(nz_rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        rsv;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1;
        logic        b0, b1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
        input logic [31:0] wd0, input logic [31:0] wd1,
        input logic rsv, input logic [4:0] ra, input logic fl,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.rsv = rsv; v.ra = ra; v.fl = fl; v.r0 = r0; v.r1 = r1;
        v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic rsv, input logic [4:0] ra, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rsv_en   = rsv;
        rsv_addr = ra;
        flush    = fl;
        rd_addr  = {r1, r0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with writes enabled: nothing may leak through.
        reset = 1'b0;
        drive(2'b11, 5'd1, 5'd31, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 5'd0, 1'b0, 5'd1, 5'd31);
        tick();
        tick();
        chk("reset_d0", rd_data[31:0], 32'h0);
        chk("reset_d1", rd_data[63:32], 32'h0);
        chk("reset_b", {30'd0, rd_busy}, 32'h0);
        reset = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd31);
        #1;
        chk("post_reset_d0", rd_data[31:0], 32'h0);
        chk("post_reset_d1", rd_data[63:32], 32'h0);
        tick();

        //            we     wa0    wa1    wd0           wd1           rsv  ra     fl   r0     r1     d0            d1            b0 b1
        tbl.push_back(mk(2'b11, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 1'b0, 5'd0, 1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 0, 0));
        tbl.push_back(mk(2'b11, 5'd5,  5'd5,  32'h11111111, 32'h22222222, 1'b0, 5'd0, 1'b0, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 0, 0));
        tbl.push_back(mk(2'b10, 5'd0,  5'd0,  32'h0,        32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5,  5'd3,  32'h22222222, 32'hAAAAAAAA, 0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd5,  32'h0,        32'h22222222, 0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd7, 1'b0, 5'd7,  5'd7,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd6,  32'h0,        32'h0,        1, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd6,  5'd7,  32'h0,        32'h0,        0, 1));
        tbl.push_back(mk(2'b01, 5'd7,  5'd0,  32'h00000007, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd7,  32'h00000007, 32'h00000007, 0, 0));
        tbl.push_back(mk(2'b01, 5'd7,  5'd0,  32'h00000070, 32'h0,        1'b1, 5'd7, 1'b0, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd1, 1'b0, 5'd7,  5'd7,  32'h00000070, 32'h00000070, 1, 1));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd2, 1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        1, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd3, 1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        1, 1));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd4, 1'b1, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 1, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd3,  5'd4,  32'hAAAAAAAA, 32'h55555555, 0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd0, 1'b0, 5'd7,  5'd3,  32'h00000070, 32'hAAAAAAAA, 0, 0));
        tbl.push_back(mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd5,  32'h0,        32'h22222222, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
                  tbl[i].rsv, tbl[i].ra, tbl[i].fl, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("vec%0d_d0", i), rd_data[31:0], tbl[i].d0);
            chk($sformatf("vec%0d_d1", i), rd_data[63:32], tbl[i].d1);
            chk($sformatf("vec%0d_b0", i), {31'd0, rd_busy[0]}, {31'd0, tbl[i].b0});
            chk($sformatf("vec%0d_b1", i), {31'd0, rd_busy[1]}, {31'd0, tbl[i].b1});
            tick();
        end

        // With ZERO_REG=0 register 0 keeps the write and honours the reserve of address 0.
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
        #1;
        chk("nz_addr0_data", nz_rd_data[31:0], 32'hDEADBEEF);
        chk("nz_addr0_busy", {31'd0, nz_rd_busy[0]}, 32'h1);
        chk("nz_addr5_data", nz_rd_data[63:32], 32'h22222222);
        tick();

        // Forwarding and same-cycle busy behaviour on address 9.
        drive(2'b01, 5'd9, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        #1;
        chk("fwd_same_d0", rd_data[31:0], BYP ? 32'h12345678 : 32'h0);
        chk("fwd_same_d1", rd_data[63:32], BYP ? 32'h12345678 : 32'h0);
        chk("fwd_same_b", {30'd0, rd_busy}, 32'h0);
        tick();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        #1;
        chk("fwd_next_d0", rd_data[31:0], 32'h12345678);
        chk("fwd_next_d1", rd_data[63:32], 32'h12345678);
        tick();
        drive(2'b01, 5'd9, 5'd0, 32'h00009999, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        #1;
        chk("fwd_rsv_d0", rd_data[31:0], BYP ? 32'h00009999 : 32'h12345678);
        chk("fwd_rsv_b0", {31'd0, rd_busy[0]}, 32'h1);
        tick();
        drive(2'b01, 5'd9, 5'd0, 32'hAAAA0009, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        #1;
        chk("fwd_wr_d0", rd_data[31:0], BYP ? 32'hAAAA0009 : 32'h00009999);
        chk("fwd_wr_b0", {31'd0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
        tick();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        #1;
        chk("fwd_after_d1", rd_data[63:32], 32'hAAAA0009);
        chk("fwd_after_b", {30'd0, rd_busy}, 32'h0);
        tick();

        // Reset asserted mid-cycle clears state at once and drops the pending write.
        drive(2'b01, 5'd10, 5'd0, 32'h0000CAFE, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd10);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_d0", rd_data[31:0], 32'h0);
        chk("async_rst_d1", rd_data[63:32], 32'h0);
        tick();
        reset = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd10);
        #1;
        chk("async_lost_d1", rd_data[63:32], 32'h0);
        chk("async_cleared_d0", rd_data[31:0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
